multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences the shared datapath (PC, unified memory, instruction register, register file, immediate extender, single ALU) through fetch, decode, execute, memory and writeback steps. It emits all datapath selects and write enables, and drives the immediate-extender format select and the ALU operation each cycle. It sits between the instruction register/ALU flags and every datapath mux and enable.

## Interface
Parameters:
- none; opcodes and encodings are fixed constants in the shared package.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag, same-cycle combinational
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register and old-PC latch enable
- result_src  out  2  result mux: 00 ALUOut, 01 data register, 10 ALU result
- alu_src_a  out  2  ALU A select: 00 PC, 01 old PC, 10 rs1 register
- alu_src_b  out  2  ALU B select: 00 rs2 register, 01 ImmExt, 10 constant 4
- reg_write  out  1  register-file write enable
- imm_src  out  2  extender format select: 00 I, 01 S, 10 B, 11 J
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  sticky illegal-opcode flag; present only under the macro

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- States and transitions. Outputs not listed in a state are 0.
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=add, result_src=10, pc_write=1. Next state: DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=add (branch target). Next state by opcode:
    - lw or sw: MEMADR
    - R-type: EXECR
    - I-ALU: EXECI
    - jal: JAL
    - beq: BEQ
    - any other opcode: ILLEGAL handling (see Configuration)
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=add. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: result_src=00, adr_src=1. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: FETCH.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=funct. Next: ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=funct. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=sub, result_src=00, branch=1. Next: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=add, result_src=00, pc_update=1. Next: ALUWB.
- pc_write = pc_update | (branch & zero). This is the only output that depends combinationally on an input; all others are Moore outputs of the state.
- imm_src is decoded from opcode in every state:
  - sw: 01
  - beq: 10
  - jal: 11
  - all others: 00
- alu_control:
  - alu_op=add gives 000; alu_op=sub gives 001.
  - alu_op=funct, by funct3:
    - 000: 001 if (opcode[5] & funct7b5), else 000
    - 010: 101
    - 110: 011
    - 111: 010
    - any other funct3: 000

## Timing
- Reset: while rst_n=0, state is FETCH and all outputs are forced to 0, including pc_write and ir_write.
- Reset release: the first rising edge after release executes FETCH with its outputs.
- Asserting rst_n mid-instruction aborts the instruction immediately and asynchronously. No partial write enable may remain asserted.
- Cycles per instruction, FETCH through last state:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-ALU: 4
  - jal: 4
  - beq: 3
- State encoding is 4 bits. Unreachable encodings return to FETCH on the next edge.

## Configuration
- RISCV_ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE moves the FSM to TRAP, where all enables are 0.
  - The FSM stays in TRAP until reset.
  - illegal rises on the edge that enters TRAP and holds; its reset value is 0.
- RISCV_ILLEGAL_TRAP_EN undefined:
  - An unknown opcode in DECODE returns the FSM to FETCH, so the instruction executes as a 2-cycle NOP.
  - The illegal port is not present.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - the opcode constants
  - the state enumeration
  - the imm_src, result_src, alu_src_a, alu_src_b and alu_control encodings
  - the alu_op encoding
- The extender imports the same imm_src constants.
- Sub-module alu_decoder is combinational: inputs alu_op, funct3, funct7b5, opcode[5]; output alu_control.

## Test plan
- Reset: hold rst_n=0 and check all outputs are 0. Release: first cycle shows ir_write=1, pc_write=1, alu_src_b=10.
- lw (opcode 0000011): sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. Check adr_src=1 in MEMREAD, reg_write=1 with result_src=01 only in cycle 5, imm_src=00 throughout.
- R-type sub (funct3=000, funct7b5=1): alu_control=001 in EXECR, reg_write=1 in cycle 4. Repeat with I-ALU and funct7b5=1: alu_control must be 000.
- beq: with zero=1 in cycle 3, pc_write=1 and imm_src=10. With zero=0, pc_write=0. The next cycle is FETCH in both cases.
- jal: imm_src=11, pc_write=1 in the JAL cycle, reg_write=1 in ALUWB, 4 cycles total. Also assert rst_n=0 during MEMWRITE of a sw: mem_write must drop to 0 immediately.
- Opcode 1111111:
  - with RISCV_ILLEGAL_TRAP_EN: illegal=1 and the FSM is stuck in TRAP for 10 cycles with no enables.
  - without the macro: FETCH follows DECODE.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// datapath select codes, ALU operation classes and the packed control word.
package riscv_ctrl_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned ALU_CTRL_W = 3;

  localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [ALU_CTRL_W-1:0] ALUC_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALUC_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALUC_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALUC_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALUC_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic             pc_update;
    logic             branch;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic             reg_write;
    alu_op_t          alu_op;
  } ctrl_word_t;

  // Immediate format follows the opcode alone, independent of FSM state.
  function automatic logic [SEL_W-1:0] imm_src_of(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SW:   imm_src_of = IMM_S;
      OP_BEQ:  imm_src_of = IMM_B;
      OP_JAL:  imm_src_of = IMM_J;
      default: imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
// The illegal flag exists only when RISCV_ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if;
  import riscv_ctrl_pkg::*;

  logic [OPCODE_W-1:0]   opcode;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic                  zero;
  logic                  pc_write;
  logic                  adr_src;
  logic                  mem_write;
  logic                  ir_write;
  logic [SEL_W-1:0]      result_src;
  logic [SEL_W-1:0]      alu_src_a;
  logic [SEL_W-1:0]      alu_src_b;
  logic                  reg_write;
  logic [SEL_W-1:0]      imm_src;
  logic [ALU_CTRL_W-1:0] alu_control;
`ifdef RISCV_ILLEGAL_TRAP_EN
  logic                  illegal;
`endif

  modport master (
    input  opcode, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, reg_write, imm_src, alu_control
`ifdef RISCV_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output opcode, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, reg_write, imm_src, alu_control
`ifdef RISCV_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class plus the
// instruction funct fields onto the ALU control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t               i_alu_op,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7b5,
  input  logic                  i_op5,
  output logic [ALU_CTRL_W-1:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALUC_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALUC_ADD;
      ALUOP_SUB: o_alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        // funct7b5 selects sub only for register-register ops (opcode bit 5 set)
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  o_alu_control = ALUC_SLT;
          3'b110:  o_alu_control = ALUC_OR;
          3'b111:  o_alu_control = ALUC_AND;
          default: o_alu_control = ALUC_ADD;
        endcase
      end
      default: o_alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Optional sticky trap on
// unknown opcodes is enabled by defining RISCV_ILLEGAL_TRAP_EN.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic       r_started;
  ctrl_word_t r_ctrl;
  ctrl_word_t w_ctrl;
  logic [ALU_CTRL_W-1:0] w_alu_control;

  // Control word is registered alongside the state it belongs to; r_started
  // holds the first post-reset edge in FETCH so FETCH executes exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_started <= 1'b0;
      r_ctrl    <= '0;
    end else begin
      r_state   <= w_next;
      r_started <= 1'b1;
      r_ctrl    <= w_ctrl;
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_ctrl        = '0;
    w_ctrl.alu_op = ALUOP_ADD;

    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
`ifdef RISCV_ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
`ifdef RISCV_ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_FETCH;
    endcase

    if (!r_started) w_next = S_FETCH;

    case (w_next)
      S_FETCH: begin
        w_ctrl.ir_write   = 1'b1;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALU;
        w_ctrl.pc_update  = 1'b1;
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.result_src = RES_DATA;
        w_ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.mem_write  = 1'b1;
      end
      S_EXECR: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_RS2;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a  = SRCA_RS1;
        w_ctrl.alu_src_b  = SRCB_RS2;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.branch     = 1'b1;
      end
      S_JAL: begin
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_update  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (r_ctrl.alu_op),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .i_op5         (bus.opcode[5]),
    .o_alu_control (w_alu_control)
  );

  // pc_write is the only output with a combinational path from an input (zero).
  assign bus.pc_write    = r_ctrl.pc_update | (r_ctrl.branch & bus.zero);
  assign bus.adr_src     = r_ctrl.adr_src;
  assign bus.mem_write   = r_ctrl.mem_write;
  assign bus.ir_write    = r_ctrl.ir_write;
  assign bus.result_src  = r_ctrl.result_src;
  assign bus.alu_src_a   = r_ctrl.alu_src_a;
  assign bus.alu_src_b   = r_ctrl.alu_src_b;
  assign bus.reg_write   = r_ctrl.reg_write;
  assign bus.imm_src     = r_started ? imm_src_of(bus.opcode) : IMM_I;
  assign bus.alu_control = w_alu_control;

`ifdef RISCV_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else        r_illegal <= r_illegal | (w_next == S_TRAP);
  end

  assign bus.illegal = r_illegal;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction table, reset
// corner cases and randomized instruction streams against a per-cycle model.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         zmode;
    int         cpi;
    logic [2:0] aluc2;
    logic       pcw_last;
  } vec_t;

  vec_t tbl[$];

  function automatic int cpi_of(input logic [6:0] op);
    case (op)
      7'b0000011: return 5;
      7'b0100011: return 4;
      7'b0110011: return 4;
      7'b0010011: return 4;
      7'b1101111: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7);
    case (f3)
      3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected output vector for cycle k of an instruction (k=0 is FETCH).
  // Layout: {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
  //          alu_src_b, reg_write, imm_src, alu_control}
  function automatic logic [15:0] exp_vec(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f7, input int k, input logic z);
    logic pcw, adr, memw, irw, regw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] aluc;
    pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0;
    res = 0; sa = 0; sb = 0; aluc = 3'b000;
    imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
          (op == 7'b1101111) ? 2'b11 : 2'b00;
    if (k == 0) begin
      pcw = 1; irw = 1; sb = 2'b10; res = 2'b10;
    end else if (k == 1) begin
      sa = 2'b01; sb = 2'b01;
    end else begin
      case (op)
        7'b0000011, 7'b0100011: begin
          if (k == 2) begin sa = 2'b10; sb = 2'b01; end
          else if (k == 3) begin adr = 1; memw = (op == 7'b0100011); end
          else begin res = 2'b01; regw = 1; end
        end
        7'b0110011: begin
          if (k == 2) aluc = funct_alu(op, f3, f7);
          if (k == 2) sa = 2'b10;
          else regw = 1;
        end
        7'b0010011: begin
          if (k == 2) begin sa = 2'b10; sb = 2'b01; aluc = funct_alu(op, f3, f7); end
          else regw = 1;
        end
        7'b1100011: begin
          sa = 2'b10; aluc = 3'b001; pcw = z;
        end
        7'b1101111: begin
          if (k == 2) begin sa = 2'b01; sb = 2'b10; pcw = 1; end
          else regw = 1;
        end
        default: ;
      endcase
    end
    return {pcw, adr, memw, irw, res, sa, sb, regw, imm, aluc};
  endfunction

  function automatic logic [15:0] act_vec();
    return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
            bus.alu_src_a, bus.alu_src_b, bus.reg_write, bus.imm_src, bus.alu_control};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Entered #1 after the edge that shows FETCH; returns #1 after the edge
  // that shows the following instruction's FETCH.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int zmode, input int n,
                           output logic [2:0] alu2, output logic pcw_last);
    alu2 = 3'b000;
    pcw_last = 1'b0;
    bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7;
    for (int k = 0; k < n; k++) begin
      bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      check($sformatf("op%02h_f%0d_c%0d", op, f3, k), act_vec(),
            exp_vec(op, f3, f7, k, bus.zero));
      if (k == 2) alu2 = bus.alu_control;
      if (k == n - 1) pcw_last = bus.pc_write;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] alu2;
    logic       pcw_last;
    logic [6:0] ops[7];
    int         nops;

    tbl.push_back('{OP_LW,  3'b010, 1'b0, 0, 5, 3'b000, 1'b0});
    tbl.push_back('{OP_SW,  3'b010, 1'b0, 0, 4, 3'b000, 1'b0});
    tbl.push_back('{OP_R,   3'b000, 1'b1, 0, 4, 3'b001, 1'b0});
    tbl.push_back('{OP_R,   3'b000, 1'b0, 0, 4, 3'b000, 1'b0});
    tbl.push_back('{OP_R,   3'b010, 1'b0, 0, 4, 3'b101, 1'b0});
    tbl.push_back('{OP_R,   3'b110, 1'b0, 0, 4, 3'b011, 1'b0});
    tbl.push_back('{OP_R,   3'b111, 1'b1, 0, 4, 3'b010, 1'b0});
    tbl.push_back('{OP_I,   3'b000, 1'b1, 0, 4, 3'b000, 1'b0});
    tbl.push_back('{OP_I,   3'b001, 1'b0, 0, 4, 3'b000, 1'b0});
    tbl.push_back('{OP_BEQ, 3'b000, 1'b0, 1, 3, 3'b001, 1'b1});
    tbl.push_back('{OP_BEQ, 3'b000, 1'b0, 0, 3, 3'b001, 1'b0});
    tbl.push_back('{OP_JAL, 3'b000, 1'b0, 0, 4, 3'b000, 1'b0});
`ifndef RISCV_ILLEGAL_TRAP_EN
    tbl.push_back('{7'h7F,  3'b000, 1'b0, 0, 2, 3'b000, 1'b0});
`endif

    // Reset held: every output low even with a store opcode presented.
    rst_n = 1'b0;
    bus.opcode = OP_SW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", act_vec(), 16'h0000);
    end
`ifdef RISCV_ILLEGAL_TRAP_EN
    check1("reset_illegal", bus.illegal, 1'b0);
`endif
    @(negedge clk) rst_n = 1'b1;
    #1 check("release_idle", act_vec(), 16'h0000);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].zmode, tbl[i].cpi, alu2, pcw_last);
      if (tbl[i].cpi > 2) check1($sformatf("tbl%0d_alu2", i), alu2 == tbl[i].aluc2, 1'b1);
      check1($sformatf("tbl%0d_pcw_last", i), pcw_last, tbl[i].pcw_last);
      check1($sformatf("tbl%0d_next_fetch", i), bus.ir_write, 1'b1);
    end

    // Reset asserted during MEMWRITE of a store must clear mem_write at once.
    bus.opcode = OP_SW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("sw_pre_rst_c%0d", k), act_vec(), exp_vec(OP_SW, 3'b010, 1'b0, k, 1'b0));
      if (k < 3) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    #1 check1("rst_mid_memw", bus.mem_write, 1'b0);
    check("rst_mid_all", act_vec(), 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized instruction stream against the per-cycle model.
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, 7'h7F};
`ifdef RISCV_ILLEGAL_TRAP_EN
    nops = 6;
`else
    nops = 7;
`endif
    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, nops - 1)];
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, cpi_of(op),
                alu2, pcw_last);
    end

`ifdef RISCV_ILLEGAL_TRAP_EN
    check1("pre_trap_illegal", bus.illegal, 1'b0);
    bus.opcode = 7'h7F; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.zero = 1'($urandom_range(0, 1));
      #1 check($sformatf("trap_entry_c%0d", k), act_vec(), exp_vec(7'h7F, 3'b000, 1'b0, k, bus.zero));
      @(posedge clk); #1;
    end
    for (int k = 0; k < 10; k++) begin
      bus.zero = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("trap_hold_c%0d", k), act_vec(), 16'h0000);
      check1($sformatf("trap_illegal_c%0d", k), bus.illegal, 1'b1);
      @(posedge clk); #1;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
